// File: rtl/blk_cda787.sv
// -----------------------------------------------------------------------------
// blk_cda787 : sequencer RAM arbiter
//
// Shares one single-port RAM (2**ADDR_W x DATA_W, 1-cycle read latency)
// between two Avalon-MM masters: m0 (sequencer CPU data port) and m1
// (debug/loader port). At most one RAM access is issued per clock. The grant
// is combinational, so the granted access drives ram_* in the same cycle its
// waitrequest is low. Read data comes back one cycle later and is flagged to
// the master that issued the read.
//
// Arbitration
//   default build : fixed priority m0 > m1. A starvation counter forces an m1
//                   grant once m1 has been denied MAX_WAIT cycles in a row.
//   SEQ_RAM_ARB_RR_EN defined : round-robin between m0/m1 using a one-bit
//                   last-grant register (m0 counts as last after reset, so m1
//                   wins the first contended cycle).
//   m1_lock : once m1 is granted with m1_lock=1, only m1 is served until the
//             first cycle m1_lock drops (that cycle arbitrates normally).
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   mN_address/byteenable/writedata   master N access (N = 0, 1)
//   mN_read, mN_write                 requests; read+write together = write
//   mN_waitrequest                    1 = not accepted this cycle (also idle)
//   mN_readdata, mN_readdatavalid     read return (data is broadcast)
//   m1_lock                           m1 keeps ownership after its grant
//   ram_address/byteenable/writedata  RAM access fields (hold when idle)
//   ram_chipselect, ram_write         RAM access strobe / write qualifier
//   ram_clken                         0 in reset, 1 otherwise
//   ram_readdata                      RAM q, valid the cycle after a read
// -----------------------------------------------------------------------------
module blk_cda787 #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  input  logic              m1_lock,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic              active;      // 0 in reset and until the first edge after release
  logic [CNT_W-1:0]  wait_cnt;
  logic              req0, req1;
  logic              gnt0, gnt1, gnt_any;
  logic              lock_hold;
  logic              force1;
  logic              pick1;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic [DATA_W-1:0] sel_writedata;
  logic [ADDR_W-1:0] address_q;
  logic [BE_W-1:0]   byteenable_q;
  logic [DATA_W-1:0] writedata_q;
  logic              rd_vld;
  logic              rd_own;      // 0 = m0, 1 = m1

`ifdef SEQ_RAM_ARB_RR_EN
  logic              last_m1;     // 1 = m1 received the most recent grant
`endif

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Reset asserts asynchronously but releases on a clock edge, so no grant can
  // be issued in the partial cycle after reset_n rises.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) active <= 1'b0;
    else          active <= 1'b1;
  end

  // While locked and m1 still asserts m1_lock, m1 is the only candidate.
  assign lock_hold = (state == LOCKED) && m1_lock;
  assign force1    = (wait_cnt == CNT_MAX);

`ifdef SEQ_RAM_ARB_RR_EN
  assign pick1 = !last_m1 || force1;
`else
  assign pick1 = force1;
`endif

  // NOTE: every signal written in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;

    if (active) begin
      if (lock_hold) begin
        gnt1 = req1;
      end else begin
        gnt1 = req1 && (!req0 || pick1);
        gnt0 = req0 && !gnt1;
      end
    end

    unique case (state)
      IDLE:    if (gnt1 && m1_lock) state_nxt = LOCKED;
      LOCKED:  if (!m1_lock)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_any = gnt0 | gnt1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Starvation counter: counts consecutive denied m1 cycles, frozen while m1
  // holds the lock (m1 is being served, so it is not starving).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!active || !req1 || gnt1) begin
      wait_cnt <= '0;
    end else if (!lock_hold && wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

`ifdef SEQ_RAM_ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     last_m1 <= 1'b0;
    else if (gnt_any) last_m1 <= gnt1;
  end
`endif

  // Access fields of the winning master.
  assign sel_write      = gnt1 ? m1_write      : m0_write;
  assign sel_address    = gnt1 ? m1_address    : m0_address;
  assign sel_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign sel_writedata  = gnt1 ? m1_writedata  : m0_writedata;

  // Last issued access fields; the RAM bus holds them while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
    end else if (gnt_any) begin
      address_q    <= sel_address;
      byteenable_q <= sel_byteenable;
      writedata_q  <= sel_writedata;
    end
  end

  assign ram_chipselect = gnt_any;
  assign ram_write      = gnt_any & sel_write;
  assign ram_address    = gnt_any ? sel_address    : address_q;
  assign ram_byteenable = gnt_any ? sel_byteenable : byteenable_q;
  assign ram_writedata  = gnt_any ? sel_writedata  : writedata_q;
  assign ram_clken      = active;

  // Read return pipeline: one stage, matching the RAM latency. A read in
  // flight when reset asserts is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld <= 1'b0;
      rd_own <= 1'b0;
    end else begin
      rd_vld <= gnt_any & !sel_write;
      rd_own <= gnt1;
    end
  end

  assign m0_waitrequest   = !gnt0;
  assign m1_waitrequest   = !gnt1;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rd_vld & !rd_own;
  assign m1_readdatavalid = rd_vld &  rd_own;

endmodule

// File: tb/tb_blk_cda787.sv
// -----------------------------------------------------------------------------
// tb_blk_cda787 : directed bench for the sequencer RAM arbiter.
// A behavioural 512x32 byte-lane RAM with 1-cycle read latency sits on the
// ram_* port. Inputs change 1 time unit after the rising edge; outputs are
// sampled 3 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_blk_cda787;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [8:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_readdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  blk_cda787 #(.ADDR_W(9), .DATA_W(32), .BE_W(4), .MAX_WAIT(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_lock          (m1_lock),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_writedata    (ram_writedata),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  // Behavioural RAM: byte-lane writes, registered read data.
  logic [31:0] mem [512];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_all;
    m0_read  = 1'b0;
    m0_write = 1'b0;
    m1_read  = 1'b0;
    m1_write = 1'b0;
    m1_lock  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m0_wait"}, m0_waitrequest, 1);
    check({tag, "_m1_wait"}, m1_waitrequest, 1);
    check({tag, "_m0_rdv"},  m0_readdatavalid, 0);
    check({tag, "_m1_rdv"},  m1_readdatavalid, 0);
    check({tag, "_cs"},      ram_chipselect, 0);
    check({tag, "_wr"},      ram_write, 0);
    check({tag, "_clken"},   ram_clken, 0);
    check({tag, "_addr"},    ram_address, 0);
    check({tag, "_be"},      ram_byteenable, 0);
    check({tag, "_wdata"},   ram_writedata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e1, p0, p1;

    // ---------------- reset state ----------------
    reset_n       = 1'b0;
    idle_all();
    m0_read       = 1'b1;            // request during reset must stay ungranted
    m0_address    = 9'h010;
    m1_address    = 9'h000;
    m0_byteenable = 4'hF;
    m1_byteenable = 4'hF;
    m0_writedata  = 32'h0;
    m1_writedata  = 32'h0;
    #12;
    check_reset_outputs("rst");
    reset_n = 1'b1;                  // released between edges
    #1;
    check("rst_release_clken", ram_clken, 0);
    check("rst_release_m0_wait", m0_waitrequest, 1);
    cyc();
    idle_all();
    settle();
    check("post_rst_clken", ram_clken, 1);
    check("post_rst_idle_wait", m0_waitrequest, 1);
    cyc();

    // ---------------- 1: m0 write then read ----------------
    m0_write = 1'b1; m0_address = 9'h010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    settle();
    check("t1_wr_wait", m0_waitrequest, 0);
    check("t1_wr_cs",   ram_chipselect, 1);
    check("t1_wr_we",   ram_write, 1);
    check("t1_wr_addr", ram_address, 9'h010);
    cyc();
    idle_all(); m0_read = 1'b1;
    settle();
    check("t1_rd_wait", m0_waitrequest, 0);
    check("t1_rd_we",   ram_write, 0);
    check("t1_wr_no_rdv", m0_readdatavalid, 0);
    cyc();
    idle_all();
    settle();
    check("t1_rdv",     m0_readdatavalid, 1);
    check("t1_rdata",   m0_readdata, 32'hDEADBEEF);
    check("t1_m1_rdv",  m1_readdatavalid, 0);
    check("t1_idle_cs", ram_chipselect, 0);
    check("t1_hold_addr",  ram_address, 9'h010);
    check("t1_hold_wdata", ram_writedata, 32'hDEADBEEF);
    cyc();
    settle();
    check("t1_rdv_once", m0_readdatavalid, 0);
    cyc();

    // ---------------- 3: m1 byte-lane write at top address ----------------
    m1_write = 1'b1; m1_address = 9'h1FF; m1_writedata = 32'hFFFFFFFF; m1_byteenable = 4'hF;
    settle();
    check("t3_wr1_wait", m1_waitrequest, 0);
    check("t3_wr1_we",   ram_write, 1);
    cyc();
    m1_writedata = 32'h12345678; m1_byteenable = 4'h3;
    settle();
    check("t3_wr2_be",   ram_byteenable, 4'h3);
    check("t3_wr2_addr", ram_address, 9'h1FF);
    cyc();
    idle_all(); m0_write = 1'b1; m0_address = 9'h000; m0_writedata = 32'hA5A5A5A5; m0_byteenable = 4'hF;
    cyc();
    idle_all(); m1_read = 1'b1;
    settle();
    check("t3_rd_wait",    m1_waitrequest, 0);
    check("t3_idle_m0_wait", m0_waitrequest, 1);
    cyc();
    idle_all(); m0_read = 1'b1; m0_address = 9'h000;
    settle();
    check("t3_m1_rdv",   m1_readdatavalid, 1);
    check("t3_m1_rdata", m1_readdata, 32'hFFFF5678);
    check("t3_m0_rdv",   m0_readdatavalid, 0);
    cyc();
    idle_all();
    settle();
    check("t3_wrap_rdv",   m0_readdatavalid, 1);
    check("t3_wrap_rdata", m0_readdata, 32'hA5A5A5A5);
    cyc();

    // ---------------- 4: m1 lock ----------------
    m1_read = 1'b1; m1_lock = 1'b1; m1_address = 9'h1FF;
    settle();
    check("t4_lock_gnt", m1_waitrequest, 0);
    cyc();
    m0_read = 1'b1; m0_address = 9'h010;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t4_m0_stall", m0_waitrequest, 1);
      check("t4_m1_gnt",   m1_waitrequest, 0);
      check("t4_m1_rdv",   m1_readdatavalid, 1);
      cyc();
    end
    m1_read = 1'b0; m1_lock = 1'b0;
    settle();
    check("t4_unlock_m0_gnt", m0_waitrequest, 0);
    check("t4_last_m1_rdv",   m1_readdatavalid, 1);
    cyc();
    idle_all();
    settle();
    check("t4_m0_rdv",   m0_readdatavalid, 1);
    check("t4_m0_rdata", m0_readdata, 32'hDEADBEEF);
    cyc();

    // ---------------- 5: reset with a read in flight ----------------
    m0_read = 1'b1; m0_address = 9'h010;
    settle();
    check("t5_rd_gnt", m0_waitrequest, 0);
    cyc();
    reset_n = 1'b0;
    idle_all();
    #1;
    check_reset_outputs("t5_async");
    cyc();
    reset_n = 1'b1;
    #1;
    check("t5_release_clken", ram_clken, 0);
    cyc();
    settle();
    check("t5_dropped_rdv", m0_readdatavalid, 0);
    check("t5_clken",       ram_clken, 1);
    cyc();

    // ---------------- 2 / 6: both masters read every cycle ----------------
    p0 = 1'b0;
    p1 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      m0_read = 1'b1; m0_address = 9'h010;
      m1_read = 1'b1; m1_address = 9'h1FF;
      settle();
`ifdef SEQ_RAM_ARB_RR_EN
      e1 = (i % 2 == 0);
`else
      e1 = (i % 9 == 8);
`endif
      check("t2_m1_wait", m1_waitrequest, {31'b0, !e1});
      check("t2_m0_wait", m0_waitrequest, {31'b0, e1});
      check("t2_m0_rdv",  m0_readdatavalid, {31'b0, p0});
      check("t2_m1_rdv",  m1_readdatavalid, {31'b0, p1});
      if (p0) check("t2_m0_rdata", m0_readdata, 32'hDEADBEEF);
      if (p1) check("t2_m1_rdata", m1_readdata, 32'hFFFF5678);
      p0 = !e1;
      p1 = e1;
      cyc();
    end
    idle_all();
    settle();
    check("t2_tail_m0_rdv", m0_readdatavalid, {31'b0, p0});
    check("t2_tail_m1_rdv", m1_readdatavalid, {31'b0, p1});
    cyc();

    // ---------------- post-reset read still correct ----------------
    m0_read = 1'b1; m0_address = 9'h010;
    cyc();
    idle_all();
    settle();
    check("t5_post_rdv",   m0_readdatavalid, 1);
    check("t5_post_rdata", m0_readdata, 32'hDEADBEEF);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
